// File: rtl/adder_tree_pipe.sv
// ============================================================================
// adder_tree_pipe
// ----------------------------------------------------------------------------
// Pipelined binary adder tree. N_IN operands of W bits are summed pairwise
// over L = log2(N_IN) register stages. Each stage grows its partial sums by
// one bit, so the final result is exact at W+L bits. A valid/ready handshake
// stalls the whole pipeline as a unit whenever the output is held.
//
// Parameters
//   N_IN    number of operands (2, 4, 8 or 16)
//   W       operand width in bits (1..32)
//   SIGNED  0 = unsigned operands, 1 = two's-complement operands
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_data     N_IN packed operands, operand i at [i*W +: W]
//   in_valid    in_data carries a sample
//   in_ready    pipeline accepts a sample this cycle
//   out_data    full-precision sum (W+L bits)
//   out_valid   out_data is valid
//   out_ready   downstream accepts out_data
//   sample_cnt  number of results delivered, wraps at 16 bits
// ============================================================================
module adder_tree_pipe #(
    parameter int N_IN   = 8,
    parameter int W      = 8,
    parameter int SIGNED = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_IN*W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [W+$clog2(N_IN)-1:0]     out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   sample_cnt
);

    localparam int L = $clog2(N_IN);

    // The whole pipeline moves in lockstep: it may shift whenever the output
    // slot is empty or is being consumed this cycle. Bubbles shift along with
    // real samples, so nothing is ever collapsed or reordered.
    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 1; k <= L; k++) begin : g_stage
        localparam int CNT = N_IN >> k;
        localparam int SW  = W + k;

        // Predecessor of this stage: the raw operands for stage 1, otherwise
        // the registered partial sums of stage k-1 (twice as many, one bit
        // narrower).
        logic [2*CNT*(SW-1)-1:0] prev_data;
        logic                    prev_valid;
        logic [CNT*SW-1:0]       sum_d;
        logic [CNT*SW-1:0]       data_q;
        logic                    valid_q;

        if (k == 1) begin : g_src
            assign prev_data  = in_data;
            assign prev_valid = in_valid;
        end else begin : g_src
            assign prev_data  = g_stage[k-1].data_q;
            assign prev_valid = g_stage[k-1].valid_q;
        end

        // Each pair is widened by one bit before adding, so the sum can never
        // overflow. The extension bit is the operand MSB for signed data and
        // zero for unsigned data.
        for (genvar j = 0; j < CNT; j++) begin : g_sum
            logic [SW-2:0] a;
            logic [SW-2:0] b;
            logic          ext_a;
            logic          ext_b;

            assign a     = prev_data[(2*j)*(SW-1)   +: SW-1];
            assign b     = prev_data[(2*j+1)*(SW-1) +: SW-1];
            assign ext_a = (SIGNED != 0) ? a[SW-2] : 1'b0;
            assign ext_b = (SIGNED != 0) ? b[SW-2] : 1'b0;

            assign sum_d[j*SW +: SW] = {ext_a, a} + {ext_b, b};
        end

        // Stage register. Data is loaded even for bubbles so that the
        // contents stay deterministic; reset wins over advance.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (advance) begin
                data_q  <= sum_d;
                valid_q <= prev_valid;
            end
        end
    end

    // Outputs come straight from the last stage register, so there is no
    // combinational path from in_data to out_data.
    assign out_data  = g_stage[L].data_q;
    assign out_valid = g_stage[L].valid_q;

    // Delivered-result counter; free-running 16-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (out_valid && out_ready) begin
            sample_cnt <= sample_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// ============================================================================
// tb_adder_tree_pipe
// ----------------------------------------------------------------------------
// Self-checking bench for adder_tree_pipe. The default configuration
// (8 x 8-bit unsigned) is tracked every cycle by a transaction-level model:
// a queue of accepted samples, each carrying its exact sum and the number of
// pipeline slots it has travelled. A second instance (4 x 8-bit signed) is
// exercised with directed vectors and literal expected sums.
// ============================================================================
module tb_adder_tree_pipe;

    localparam int N_IN = 8;
    localparam int W    = 8;
    localparam int L    = 3;
    localparam int OW   = W + L;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_IN*W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [OW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       sample_cnt;

    logic [31:0]       s_in_data;
    logic              s_in_valid;
    logic              s_in_ready;
    logic [9:0]        s_out_data;
    logic              s_out_valid;
    logic              s_out_ready;
    logic [15:0]       s_sample_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_tree_pipe #(.N_IN(N_IN), .W(W), .SIGNED(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sample_cnt (sample_cnt)
    );

    adder_tree_pipe #(.N_IN(4), .W(8), .SIGNED(1)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .in_data    (s_in_data),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .out_data   (s_out_data),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .sample_cnt (s_sample_cnt)
    );

    // One comparison: counts it, reports it when the values differ.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at t=%0t",
                     name, actual, required, $time);
        end
    endtask

    // Drives the default instance's inputs (call just after a rising edge).
    task automatic applyStimulus(input logic v, input logic [63:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic applyReset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        s_in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Plain arithmetic sum of the eight unsigned operands.
    function automatic logic [OW-1:0] model_sum(input logic [N_IN*W-1:0] d);
        int acc = 0;
        for (int i = 0; i < N_IN; i++) acc += int'(d[i*W +: W]);
        return OW'(acc);
    endfunction

    function automatic logic [63:0] pattern(input int c);
        logic [63:0] p;
        for (int j = 0; j < N_IN; j++) p[j*W +: W] = 8'(c * (j + 3) + j);
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Transaction model of the default instance. Each accepted sample is
    // queued with its exact sum and the number of slots it has moved
    // through; it is visible at the output once it has moved through all L.
    // Outputs are compared on the falling edge, then the model is advanced
    // with the inputs that the next rising edge will sample.
    // ------------------------------------------------------------------
    typedef struct {
        logic [OW-1:0] sum;
        int            age;
    } item_t;

    item_t       pipe_q[$];
    bit          live = 1'b0;
    logic [15:0] m_cnt = '0;

    always @(negedge clk) begin
        bit    ev;
        item_t it;
        ev = live && (pipe_q.size() > 0) && (pipe_q[0].age == L);
        if (live) begin
            checkOutput("model out_valid", 32'(out_valid), 32'(ev));
            if (ev) checkOutput("model out_data", 32'(out_data), 32'(pipe_q[0].sum));
            checkOutput("model in_ready", 32'(in_ready), 32'(!ev || out_ready));
            checkOutput("model sample_cnt", 32'(sample_cnt), 32'(m_cnt));
        end
        if (rst) begin
            pipe_q.delete();
            m_cnt = '0;
            live  = 1'b1;
        end else if (live && (!ev || out_ready)) begin
            if (ev) begin
                void'(pipe_q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            for (int i = 0; i < pipe_q.size(); i++) pipe_q[i].age = pipe_q[i].age + 1;
            if (in_valid) begin
                it.sum = model_sum(in_data);
                it.age = 1;
                pipe_q.push_back(it);
            end
        end
    end

    // Signed instance: one sample, result expected two edges after acceptance.
    task automatic runSignedVector(input string name, input logic [31:0] ops,
                                   input logic [9:0] want);
        s_in_data  = ops;
        s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        checkOutput({name, " early"}, 32'(s_out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput({name, " valid"}, 32'(s_out_valid), 32'd1);
        checkOutput({name, " data"}, 32'(s_out_data), 32'(want));
        @(posedge clk); #1;
        checkOutput({name, " gone"}, 32'(s_out_valid), 32'd0);
    endtask

    initial begin
        #1_500_000;
        failures++;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_out_ready = 1'b1;

        // Reset state
        applyReset();
        #1;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_data", 32'(out_data), 32'd0);
        checkOutput("reset sample_cnt", 32'(sample_cnt), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset signed out_data", 32'(s_out_data), 32'd0);

        // Single sample 1..8: sum 36, visible only after the third edge
        $display("[TB] single sample latency");
        applyStimulus(1'b1, 64'h0807060504030201, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            applyStimulus(1'b0, 64'd0, 1'b1);
            #1;
            checkOutput("single valid", 32'(out_valid), 32'(c == 3));
            if (c == 3) checkOutput("single data", 32'(out_data), 32'h024);
        end

        // Four back-to-back all-ones samples: 8*255 = 2040
        $display("[TB] back-to-back maximum operands");
        applyReset();
        applyStimulus(1'b1, {8{8'hFF}}, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            applyStimulus(c < 4, {8{8'hFF}}, 1'b1);
            #1;
            checkOutput("burst valid", 32'(out_valid), 32'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) checkOutput("burst data", 32'(out_data), 32'h7F8);
        end
        checkOutput("burst sample_cnt", 32'(sample_cnt), 32'd4);

        // Sums 1,2,3 with the output held for five edges once the first lands
        $display("[TB] backpressure stall");
        applyReset();
        applyStimulus(1'b1, 64'd1, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            logic [31:0] want;
            @(posedge clk); #1;
            applyStimulus(c < 3, 64'(c + 1), !(c >= 3 && c <= 7));
            #1;
            want = (c <= 8) ? 32'd1 : 32'(c - 7);
            checkOutput("stall valid", 32'(out_valid), 32'(c >= 3 && c <= 10));
            if (c >= 3 && c <= 10) checkOutput("stall data", 32'(out_data), want);
            checkOutput("stall in_ready", 32'(in_ready), 32'(!(c >= 3 && c <= 7)));
        end
        checkOutput("stall sample_cnt", 32'(sample_cnt), 32'd3);

        // Reset with two samples in flight: neither may ever emerge
        $display("[TB] mid-stream reset");
        applyReset();
        applyStimulus(1'b1, {8{8'h01}}, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            rst = (c == 2);
            applyStimulus(c < 2, {8{8'h01}}, 1'b1);
            #1;
            if (c >= 3) begin
                checkOutput("flush valid", 32'(out_valid), 32'd0);
                checkOutput("flush sample_cnt", 32'(sample_cnt), 32'd0);
            end
        end
        applyStimulus(1'b1, 64'h1020304050607080, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            applyStimulus(1'b0, 64'd0, 1'b1);
            #1;
            checkOutput("post-flush valid", 32'(out_valid), 32'(c == 3));
            if (c == 3) checkOutput("post-flush data", 32'(out_data), 32'h240);
        end

        // Signed 4 x 8-bit vectors
        $display("[TB] signed vectors");
        runSignedVector("signed -128-128+127-1", {8'hFF, 8'h7F, 8'h80, 8'h80}, 10'h37E);
        runSignedVector("signed -128+127", {8'h00, 8'h00, 8'h7F, 8'h80}, 10'h3FF);
        runSignedVector("signed 4x127", {4{8'h7F}}, 10'h1FC);
        runSignedVector("signed 4x-128", {4{8'h80}}, 10'h200);
        runSignedVector("signed cancel", {8'hFE, 8'h02, 8'hFF, 8'h01}, 10'h000);

        // 65536 deliveries: the counter passes 0xFFFF and wraps to zero
        $display("[TB] sample counter wrap");
        applyReset();
        applyStimulus(1'b1, pattern(0), 1'b1);
        for (int c = 1; c <= 65540; c++) begin
            @(posedge clk); #1;
            applyStimulus(c < 65536, pattern(c), 1'b1);
            if (c == 65538) checkOutput("wrap at 65535", 32'(sample_cnt), 32'hFFFF);
            if (c == 65539) checkOutput("wrap at 65536", 32'(sample_cnt), 32'h0000);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
